// File: rtl/clk_div_gen.sv
// Programmable clock divider that produces a square wave or a one-cycle pulse train.
// Divisor and mode changes made while running are deferred to the next terminal count,
// so every period that has started finishes with the settings it started with.
//
// state   | meaning
// --------+--------------------------------------------------------------------
// ST_IDLE | stopped; outputs low; loads and mode are applied directly
// ST_RUN  | counting 0..active_div-1; changes are held until the next boundary
module clk_div_gen #(
  parameter int          WIDTH       = 28,
  parameter int unsigned DEFAULT_DIV = 200000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] L_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] L_ONE         = WIDTH'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_active_div;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_active_mode;
  logic             r_pending;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_load_err;

  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_terminal;
  logic             w_mode_chg;
  logic             w_apply;
  logic [WIDTH-1:0] w_next_div;

  // A zero divisor is meaningless, so it is rejected and flagged instead of loaded.
  assign w_load_ok  = div_load & (div_val != '0);
  assign w_load_bad = div_load & (div_val == '0);
  // ">=" keeps the counter bounded even if it were ever above the terminal value.
  assign w_terminal = (r_count >= (r_active_div - L_ONE));
  assign w_mode_chg = (mode != r_active_mode);
  // A load or mode change arriving on the terminal edge itself joins that boundary.
  assign w_apply    = r_pending | w_load_ok | w_mode_chg;
  // r_pend_div always equals the divisor for the next period, even with nothing pending,
  // so a mode-only change reapplies the current divisor unchanged.
  assign w_next_div = w_load_ok ? div_val : r_pend_div;

  // Sequencing FSM, counter and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_active_div  <= L_DEFAULT_DIV;
      r_pend_div    <= L_DEFAULT_DIV;
      r_active_mode <= 1'b0;
      r_pending     <= 1'b0;
      r_clk_out     <= 1'b0;
      r_tick        <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_load_err <= w_load_bad;
      case (r_state)
        ST_IDLE: begin
          r_count       <= '0;
          r_clk_out     <= 1'b0;
          r_tick        <= 1'b0;
          r_pending     <= 1'b0;
          r_active_mode <= mode;
          if (w_load_ok) begin
            r_active_div <= div_val;
            r_pend_div   <= div_val;
          end
          if (en) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!en) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
            if (w_load_ok) begin
              r_active_div <= div_val;
              r_pend_div   <= div_val;
            end else if (r_pending) begin
              r_active_div <= r_pend_div;
            end
          end else if (w_terminal) begin
            r_count   <= '0;
            r_tick    <= 1'b1;
            r_clk_out <= r_active_mode ? 1'b1 : ~r_clk_out;
            if (w_apply) begin
              r_active_div  <= w_next_div;
              r_pend_div    <= w_next_div;
              r_active_mode <= mode;
              r_pending     <= 1'b0;
            end
          end else begin
            r_count <= r_count + L_ONE;
            r_tick  <= 1'b0;
            if (r_active_mode) r_clk_out <= 1'b0;
            if (w_load_ok) r_pend_div <= div_val;
            if (w_load_ok || w_mode_chg) r_pending <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign clk_out  = r_clk_out;
  assign tick     = r_tick;
  assign pending  = r_pending;
  assign load_err = r_load_err;

endmodule
